load_store_unit: RTL and testbench

Memory-access initiator that sits between the datapath and the word-wide data memory port (7-bit word address, async read, write on posedge clk when mem_write).
- Accepts byte, halfword and word load/store requests on a byte address.
- Drives mem_read/mem_write/address/write_data toward the memory.
- Builds sub-word stores by read-modify-write.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned requests with resp_err instead of truncating the address.
module load_store_unit #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t                  state_q, state_d;
    logic                    write_q, write_d, signed_q, signed_d, resp_err_q, resp_err_d;
    logic [1:0]              size_q, size_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, word_q, word_d, resp_rdata_q, resp_rdata_d;
    logic                    mis;
    logic [4:0]              sh;
    logic [15:0]             shifted;
    logic [DATA_WIDTH-1:0]   lane_mask, merged, load_val;
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    // Byte lanes shift by 8*offset; halfwords only ever sit at bit 0 or bit 16.
    assign sh        = size_q == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    assign lane_mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign merged    = size_q[1] ? wdata_q : (word_q & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    assign shifted   = 16'(mem_read_data >> sh);
    assign load_val  = size_q[1] ? mem_read_data :
                       size_q[0] ? {{16{signed_q & shifted[15]}}, shifted} :
                                   {{24{signed_q & shifted[7]}}, shifted[7:0]};
    assign req_ready      = state_q == IDLE;
    assign resp_valid     = state_q == DONE;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_read       = state_q == READ;
    assign mem_write      = state_q == WRITE;
    assign mem_write_data = mem_write ? merged : '0;
    assign mem_address    = addr_q[ADDR_WIDTH+1:2];
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d      = req_write;
                size_d       = req_size;
                signed_d     = req_signed;
                addr_d       = req_addr;
                wdata_d      = req_wdata;
                state_d      = mis ? DONE : (req_write && req_size[1]) ? WRITE : READ;
                resp_rdata_d = mis ? '0 : resp_rdata_q;
                resp_err_d   = mis ? 1'b1 : resp_err_q;
            end
            READ: begin
                word_d       = mem_read_data;
                state_d      = write_q ? WRITE : DONE;
                resp_rdata_d = write_q ? resp_rdata_q : load_val;
                resp_err_d   = write_q ? resp_err_q : 1'b0;
            end
            WRITE: begin
                state_d      = DONE;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_q       <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a 128-word async-read memory.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0, resp_rdata, mem_write_data, mem_read_data;
    logic        resp_valid, resp_err, mem_read, mem_write;
    logic [6:0]  mem_address;
    logic [31:0] mem [128];
    logic [31:0] ref_mem [128];
    int checks = 0, errors = 0;
    typedef struct {logic w; logic [1:0] sz; logic sg; logic [8:0] a; logic [31:0] wd;} req_t;
    typedef struct {int lat; logic [31:0] rd; logic er; int nrd; int nwr; logic [6:0] wa; logic [31:0] wd;} exp_t;
    exp_t sb[$];
    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
    assign mem_read_data = mem[mem_address];
    task automatic model(input req_t r);
        exp_t e;
        logic [31:0] w;
        logic [7:0] b;
        logic [15:0] h;
        logic mis;
        int wi;
        wi = int'(r.a[8:2]);
        w = ref_mem[wi];
        e = '{0, 32'h0, 1'b0, 0, 0, 7'h0, 32'h0};
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (r.sz == 2'd1 && r.a[0]) || (r.sz >= 2'd2 && r.a[1:0] != 2'd0);
`endif
        if (mis) begin
            e.lat = 1; e.er = 1'b1;
        end else if (!r.w) begin
            e.lat = 2; e.nrd = 1;
            b = w[8*r.a[1:0] +: 8];
            h = r.a[1] ? w[31:16] : w[15:0];
            if (r.sz == 2'd0) e.rd = r.sg ? {{24{b[7]}}, b} : {24'h0, b};
            else if (r.sz == 2'd1) e.rd = r.sg ? {{16{h[15]}}, h} : {16'h0, h};
            else e.rd = w;
        end else begin
            if (r.sz >= 2'd2) w = r.wd;
            else if (r.sz == 2'd0) w[8*r.a[1:0] +: 8] = r.wd[7:0];
            else if (r.a[1]) w[31:16] = r.wd[15:0];
            else w[15:0] = r.wd[15:0];
            e.lat = r.sz >= 2'd2 ? 2 : 3; e.nrd = r.sz >= 2'd2 ? 0 : 1; e.nwr = 1;
            e.wa = r.a[8:2]; e.wd = w;
            ref_mem[wi] = w;
        end
        sb.push_back(e);
    endtask
    task automatic run(input req_t r, output exp_t o);
        o = '{-1, 32'h0, 1'b0, 0, 0, 7'h0, 32'h0};
        @(negedge clk);
        req_valid = 1'b1; req_write = r.w; req_size = r.sz; req_signed = r.sg;
        req_addr = r.a; req_wdata = r.wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~r.w; req_size = ~r.sz; req_signed = ~r.sg;
        req_addr = 9'($urandom); req_wdata = $urandom;
        for (int c = 1; c <= 8 && o.lat < 0; c++) begin
            @(negedge clk);
            if (mem_read) o.nrd++;
            if (mem_read && mem_write) o.nrd += 100;
            if (mem_write) begin o.nwr++; o.wa = mem_address; o.wd = mem_write_data; end
            if (resp_valid) begin o.lat = c; o.rd = resp_rdata; o.er = resp_err; end
        end
    endtask
    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_address, mem_write_data}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset: got rdy=%b rv=%b rd=%h err=%b mr=%b mw=%b ma=%0d mwd=%h, want rdy=1 rest 0",
                     req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_address, mem_write_data);
        end
    endtask
    task automatic test_word_store_load;
        req_t t[5] = '{'{1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF}, '{1'b0, 2'd0, 1'b1, 9'h013, 32'h0},
                       '{1'b0, 2'd0, 1'b0, 9'h013, 32'h0}, '{1'b0, 2'd1, 1'b0, 9'h010, 32'h0},
                       '{1'b0, 2'd1, 1'b1, 9'h012, 32'h0}};
        exp_t o, e;
        foreach (t[i]) begin
            model(t[i]); run(t[i], o); e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL word_store_load[%0d]: got lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h, want lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h",
                         i, o.lat, o.rd, o.er, o.nrd, o.nwr, o.wa, o.wd, e.lat, e.rd, e.er, e.nrd, e.nwr, e.wa, e.wd);
            end
        end
    endtask
    task automatic test_subword_store;
        req_t t[6] = '{'{1'b1, 2'd0, 1'b0, 9'h011, 32'hFFFF_FFAA}, '{1'b0, 2'd2, 1'b0, 9'h010, 32'h0},
                       '{1'b1, 2'd1, 1'b0, 9'h016, 32'h5A5A_9234}, '{1'b0, 2'd1, 1'b1, 9'h016, 32'h0},
                       '{1'b1, 2'd0, 1'b0, 9'h014, 32'h0000_0080}, '{1'b0, 2'd0, 1'b1, 9'h014, 32'h0}};
        exp_t o, e;
        foreach (t[i]) begin
            model(t[i]); run(t[i], o); e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL subword_store[%0d]: got lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h, want lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h",
                         i, o.lat, o.rd, o.er, o.nrd, o.nwr, o.wa, o.wd, e.lat, e.rd, e.er, e.nrd, e.nwr, e.wa, e.wd);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b0, e.rd}) begin
            errors++;
            $display("FAIL rdata_hold: got rv=%b rd=%h, want rv=0 rd=%h", resp_valid, resp_rdata, e.rd);
        end
    endtask
    task automatic test_misaligned;
        req_t t[6] = '{'{1'b1, 2'd1, 1'b0, 9'h011, 32'h0000_5566}, '{1'b0, 2'd2, 1'b0, 9'h012, 32'h0},
                       '{1'b1, 2'd3, 1'b0, 9'h023, 32'h1234_5678}, '{1'b0, 2'd1, 1'b1, 9'h015, 32'h0},
                       '{1'b0, 2'd2, 1'b0, 9'h010, 32'h0}, '{1'b0, 2'd3, 1'b0, 9'h020, 32'h0}};
        exp_t o, e;
        int bad = 0;
        foreach (t[i]) begin
            model(t[i]); run(t[i], o); e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL misaligned[%0d]: got lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h, want lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h",
                         i, o.lat, o.rd, o.er, o.nrd, o.nwr, o.wa, o.wd, e.lat, e.rd, e.er, e.nrd, e.nwr, e.wa, e.wd);
            end
        end
        foreach (mem[i]) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL misaligned_mem: got %0d differing words, want 0", bad); end
    endtask
    task automatic test_back_to_back;
        exp_t o, e;
        req_t r;
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            r = '{1'($urandom), 2'($urandom), 1'($urandom), 9'($urandom_range(0, 47)), $urandom};
            model(r); run(r, o); e = sb.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] w=%b sz=%0d a=%h: got lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h, want lat=%0d rd=%h err=%b nrd=%0d nwr=%0d wa=%0d wd=%h",
                         i, r.w, r.sz, r.a, o.lat, o.rd, o.er, o.nrd, o.nwr, o.wa, o.wd, e.lat, e.rd, e.er, e.nrd, e.nwr, e.wa, e.wd);
            end
        end
        foreach (mem[i]) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL back_to_back_mem: got %0d differing words, want 0", bad); end
    endtask
    task automatic test_reset_mid_op;
        int nwr = 0, nrv = 0, bad = 0;
        logic rdy;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 9'h021; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        if (mem_write) nwr++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        rdy = req_ready;
        for (int c = 0; c < 4; c++) begin
            if (mem_write) nwr++;
            if (resp_valid) nrv++;
            @(negedge clk);
        end
        checks++;
        if ({rdy, nwr, nrv} !== {1'b1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_op: got rdy=%b writes=%0d resps=%0d, want rdy=1 writes=0 resps=0", rdy, nwr, nrv);
        end
        foreach (mem[i]) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_mid_op_mem: got %0d differing words, want 0", bad); end
    endtask
    initial begin
        foreach (mem[i]) begin mem[i] = '0; ref_mem[i] = '0; end
        test_reset;
        test_word_store_load;
        test_subword_store;
        test_misaligned;
        test_back_to_back;
        test_reset_mid_op;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
